// File: rtl/gate_pkg.sv
// Shared definitions for the gate unit: op and state encodings, sweep
// geometry and the lane-wise gate evaluation function.
package gate_pkg;

    // Widest operand the evaluation function handles; callers zero-extend.
    localparam int GATE_MAX_W = 64;

    // Truth-table rows driven by the sweep sequencer: 00, 01, 10, 11.
    localparam int SWEEP_ROWS = 4;

    typedef enum logic [2:0] {
        GOP_AND  = 3'd0,
        GOP_OR   = 3'd1,
        GOP_NAND = 3'd2,
        GOP_NOR  = 3'd3,
        GOP_XOR  = 3'd4,
        GOP_XNOR = 3'd5,
        GOP_NOT  = 3'd6,
        GOP_BUF  = 3'd7
    } gate_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } gate_state_e;

    // Lane-wise gate; NOT and BUF look only at operand A.
    function automatic logic [GATE_MAX_W-1:0] gate_eval(
        input gate_op_e                op,
        input logic [GATE_MAX_W-1:0]   a,
        input logic [GATE_MAX_W-1:0]   b
    );
        logic [GATE_MAX_W-1:0] r;
        case (op)
            GOP_AND:  r = a & b;
            GOP_OR:   r = a | b;
            GOP_NAND: r = ~(a & b);
            GOP_NOR:  r = ~(a | b);
            GOP_XOR:  r = a ^ b;
            GOP_XNOR: r = ~(a ^ b);
            GOP_NOT:  r = ~a;
            GOP_BUF:  r = a;
            default:  r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_lane_array.sv
// Combinational WIDTH-lane gate evaluator. Operands are zero-extended to
// the package width, evaluated, and the low WIDTH lanes returned.
module gate_lane_array
    import gate_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [GATE_MAX_W-1:0] a_ext;
    logic [GATE_MAX_W-1:0] b_ext;
    logic [GATE_MAX_W-1:0] y_ext;
    // Lanes above WIDTH are computed but deliberately dropped.
    logic                  unused_upper_lanes;

    // Widen the operands and evaluate all lanes in one call.
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        a_ext[WIDTH-1:0] = a;
        b_ext[WIDTH-1:0] = b;
        y_ext = gate_eval(gate_op_e'(op), a_ext, b_ext);
    end

    assign y                  = y_ext[WIDTH-1:0];
    assign unused_upper_lanes = ^y_ext;

endmodule

// File: rtl/gate_unit_seq.sv
// Registered WIDTH-lane gate unit with valid/ready output and a built-in
// truth-table sweep sequencer. Optional registered even parity of y is
// enabled by defining GATE_PARITY_EN (adds the y_par port).
module gate_unit_seq
    import gate_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int HOLD  = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready
`ifdef GATE_PARITY_EN
    ,
    output logic             y_par
`endif
);

    localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
    localparam logic [1:0]      LAST_ROW  = 2'(SWEEP_ROWS - 1);

    gate_state_e      state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             out_valid_q, out_valid_d;
    // Keeps in_ready low until the first clock after reset release.
    logic             ready_en_q, ready_en_d;

    logic             can_load;
    logic             in_fire;
    logic             row_fire;
    logic             load;

    logic [2:0]       eval_op;
    logic [WIDTH-1:0] eval_a;
    logic [WIDTH-1:0] eval_b;
    logic [WIDTH-1:0] eval_y;

    // The output register can take a new value if it is empty or draining now.
    assign can_load = !out_valid_q || out_ready;

    // Evaluator input select: sweep row vector while sweeping, else the port operands.
    always_comb begin
        eval_op = op;
        eval_a  = a;
        eval_b  = b;
        if (state_q == ST_SWEEP) begin
            eval_op = op_q;
            eval_a  = {WIDTH{row_q[1]}};
            eval_b  = {WIDTH{row_q[0]}};
        end
    end

    gate_lane_array #(
        .WIDTH (WIDTH)
    ) u_lanes (
        .op (eval_op),
        .a  (eval_a),
        .b  (eval_b),
        .y  (eval_y)
    );

    // Sequencer next state and handshake/status outputs.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        hold_d     = hold_q;
        op_d       = op_q;
        ready_en_d = 1'b1;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        in_fire    = 1'b0;
        row_fire   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = ready_en_q && can_load;
                in_fire  = in_valid && in_ready;
                if (start) begin
                    op_d    = op;
                    row_d   = 2'd0;
                    hold_d  = '0;
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                busy = 1'b1;
                if (hold_q == HOLD_LAST) begin
                    // Row is due; if the output is blocked, hold stays put and we stall.
                    if (can_load) begin
                        row_fire = 1'b1;
                        hold_d   = '0;
                        if (row_q == LAST_ROW) begin
                            state_d = ST_DONE;
                        end else begin
                            row_d = row_q + 2'd1;
                        end
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register next value: load wins over drain, drain alone clears valid.
    always_comb begin
        load        = in_fire || row_fire;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        if (load) begin
            y_d         = eval_y;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers; reset also discards any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= 2'd0;
            hold_q      <= '0;
            op_q        <= 3'd0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            op_q        <= op_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            ready_en_q  <= ready_en_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

`ifdef GATE_PARITY_EN
    logic par_q, par_d;

    // Parity is captured from the same evaluation that loads y.
    always_comb begin
        par_d = par_q;
        if (load) begin
            par_d = ^eval_y;
        end
    end

    // Parity register, cleared with the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign y_par = par_q;
`endif

endmodule

// File: tb/tb_gate_unit_seq.sv
// Self-checking bench for gate_unit_seq (WIDTH=4, HOLD=20). Works with or
// without GATE_PARITY_EN.
module tb_gate_unit_seq;

    localparam int WIDTH = 4;
    localparam int HOLD  = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             in_ready;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
`ifdef GATE_PARITY_EN
    logic             y_par;
`endif

    always #5 clk = ~clk;

    gate_unit_seq #(
        .WIDTH (WIDTH),
        .HOLD  (HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef GATE_PARITY_EN
        ,
        .y_par     (y_par)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference gate: per-op truth table indexed by {a_bit, b_bit}.
    function automatic logic [WIDTH-1:0] model_f(input int o, input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] z);
        logic [3:0]       tt;
        logic [1:0]       idx;
        logic [WIDTH-1:0] r;
        case (o)
            0:       tt = 4'b1000;
            1:       tt = 4'b1110;
            2:       tt = 4'b0111;
            3:       tt = 4'b0001;
            4:       tt = 4'b0110;
            5:       tt = 4'b1001;
            6:       tt = 4'b0011;
            default: tt = 4'b1100;
        endcase
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx  = {x[i], z[i]};
            r[i] = tt[idx];
        end
        return r;
    endfunction

    // Behavioural model: mode 0 idle, 1 sweeping, 2 done cycle.
    logic             m_valid, m_valid_n;
    logic [WIDTH-1:0] m_y, m_y_n;
    int               m_mode, m_mode_n;
    int               m_row, m_row_n;
    int               m_cnt, m_cnt_n;
    int               m_op, m_op_n;
    logic             m_started;
    logic             m_can, m_ld;
    logic [WIDTH-1:0] m_v, m_ra, m_rb;

    always_comb begin
        m_valid_n = m_valid;
        m_y_n     = m_y;
        m_mode_n  = m_mode;
        m_row_n   = m_row;
        m_cnt_n   = m_cnt;
        m_op_n    = m_op;
        m_can     = !m_valid || out_ready;
        m_ld      = 1'b0;
        m_v       = m_y;
        m_ra      = (m_row >= 2) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        m_rb      = (m_row % 2 == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        if (m_mode == 0) begin
            if (m_started && m_can && in_valid) begin
                m_ld = 1'b1;
                m_v  = model_f(int'(op), a, b);
            end
            if (start) begin
                m_op_n   = int'(op);
                m_row_n  = 0;
                m_cnt_n  = 0;
                m_mode_n = 1;
            end
        end else if (m_mode == 1) begin
            if (m_cnt < HOLD - 1) begin
                m_cnt_n = m_cnt + 1;
            end else if (m_can) begin
                m_ld    = 1'b1;
                m_v     = model_f(m_op, m_ra, m_rb);
                m_cnt_n = 0;
                if (m_row == 3) m_mode_n = 2;
                else            m_row_n  = m_row + 1;
            end
        end else begin
            m_mode_n = 0;
        end
        if (m_ld) begin
            m_valid_n = 1'b1;
            m_y_n     = m_v;
        end else if (out_ready) begin
            m_valid_n = 1'b0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid   <= 1'b0;
            m_y       <= '0;
            m_mode    <= 0;
            m_row     <= 0;
            m_cnt     <= 0;
            m_op      <= 0;
            m_started <= 1'b0;
        end else begin
            m_valid   <= m_valid_n;
            m_y       <= m_y_n;
            m_mode    <= m_mode_n;
            m_row     <= m_row_n;
            m_cnt     <= m_cnt_n;
            m_op      <= m_op_n;
            m_started <= 1'b1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("y", 32'(y), 32'(m_y));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("in_ready", 32'(in_ready), 32'(m_started && (m_mode == 0) && (!m_valid || out_ready)));
            chk("busy", 32'(busy), 32'(m_mode == 1));
            chk("done", 32'(done), 32'(m_mode == 2));
`ifdef GATE_PARITY_EN
            chk("y_par", 32'(y_par), 32'(^m_y));
`endif
        end
    end

    // Output transfer and done-pulse log.
    int               cyc = 0;
    int               n_out = 0;
    int               n_done = 0;
    int               done_cyc = 0;
    logic [WIDTH-1:0] ys [0:63];
    int               tcyc [0:63];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (out_valid && out_ready && n_out < 64) begin
                ys[n_out]   <= y;
                tcyc[n_out] <= cyc;
                n_out       <= n_out + 1;
            end
            if (done) begin
                n_done   <= n_done + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_y"}, 32'(y), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
`ifdef GATE_PARITY_EN
        chk({tag, "_y_par"}, 32'(y_par), 32'd0);
`endif
    endtask

    task automatic wait_done(input int bd, input string tag);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (n_done > bd) begin
                got = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
    endtask

    logic [WIDTH-1:0] exp_ops [0:7];
    int               base;
    int               bd;
    logic             got_out;

    initial begin
        exp_ops = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1100};
        rst = 1'b1; in_valid = 1'b0; start = 1'b0; op = 3'd0;
        a = '0; b = '0; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_before_first_clk", 32'(in_ready), 32'd0);
        tick();
        chk("in_ready_after_first_clk", 32'(in_ready), 32'd1);

        // All eight ops on the lab vector pair.
        a = 4'b1100; b = 4'b1010;
        for (int o = 0; o < 8; o++) begin
            op = 3'(o); in_valid = 1'b1;
            tick();
            chk($sformatf("op%0d_y", o), 32'(y), 32'(exp_ops[o]));
            chk($sformatf("op%0d_valid", o), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("drained_valid", 32'(out_valid), 32'd0);

        // Backpressure: hold y, then drain and load in the same cycle.
        out_ready = 1'b0; op = 3'd0; in_valid = 1'b1;
        tick();
        chk("bp_first_y", 32'(y), 32'(4'b1000));
        op = 3'd1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_y_held", 32'(y), 32'(4'b1000));
            chk("bp_valid_held", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", 32'(in_ready), 32'd1);
        tick();
        chk("bp_second_y", 32'(y), 32'(4'b1110));
        chk("bp_valid_continuous", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();

        // Asynchronous reset while a result is pending.
        out_ready = 1'b0; op = 3'd7; a = 4'b0101; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pre_reset_y", 32'(y), 32'(4'b0101));
        #2 rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        tick();

        // NAND sweep with in_valid pushed throughout.
        base = n_out; bd = n_done;
        op = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("nand_busy", 32'(busy), 32'd1);
        op = 3'd0; a = 4'b1111; b = 4'b1111; in_valid = 1'b1;
        wait_done(bd, "nand");
        repeat (3) tick();
        chk("nand_done_count", 32'(n_done - bd), 32'd1);
        chk("nand_out_count", 32'(n_out - base), 32'd4);
        chk("nand_row0", 32'(ys[base]),   32'(4'b1111));
        chk("nand_row1", 32'(ys[base+1]), 32'(4'b1111));
        chk("nand_row2", 32'(ys[base+2]), 32'(4'b1111));
        chk("nand_row3", 32'(ys[base+3]), 32'(4'b0000));
        for (int k = 1; k < 4; k++)
            chk($sformatf("nand_gap%0d", k), 32'(tcyc[base+k] - tcyc[base+k-1]), 32'(HOLD));
        chk("nand_done_with_last", 32'(done_cyc), 32'(tcyc[base+3]));

        // NOR sweep stalled from row 2.
        base = n_out; bd = n_done;
        op = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        got_out = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (n_out - base >= 2) begin
                got_out = 1'b1;
                break;
            end
        end
        chk("nor_two_rows", 32'(got_out), 32'd1);
        out_ready = 1'b0;
        repeat (50) tick();
        chk("nor_stall_busy", 32'(busy), 32'd1);
        chk("nor_stall_valid", 32'(out_valid), 32'd1);
        chk("nor_stall_y", 32'(y), 32'(4'b0000));
        chk("nor_stall_outs", 32'(n_out - base), 32'd2);
        chk("nor_stall_no_done", 32'(n_done - bd), 32'd0);
        out_ready = 1'b1;
        wait_done(bd, "nor");
        repeat (3) tick();
        chk("nor_out_count", 32'(n_out - base), 32'd4);
        chk("nor_row0", 32'(ys[base]),   32'(4'b1111));
        chk("nor_row1", 32'(ys[base+1]), 32'(4'b0000));
        chk("nor_row2", 32'(ys[base+2]), 32'(4'b0000));
        chk("nor_row3", 32'(ys[base+3]), 32'(4'b0000));
        chk("nor_done_count", 32'(n_done - bd), 32'd1);

        // Abort a sweep during row 1, then run a fresh one.
        base = n_out; bd = n_done;
        op = 3'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (n_out - base >= 1) break;
        end
        repeat (10) tick();
        chk("abort_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("abort_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) tick();
        chk("abort_no_done", 32'(n_done - bd), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        base = n_out; bd = n_done;
        op = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(bd, "restart");
        repeat (3) tick();
        chk("restart_out_count", 32'(n_out - base), 32'd4);
        chk("restart_row1", 32'(ys[base+1]), 32'(4'b0000));
        chk("restart_row2", 32'(ys[base+2]), 32'(4'b1111));
        chk("restart_done_count", 32'(n_done - bd), 32'd1);

        // XOR result (and its parity when enabled).
        op = 3'd4; a = 4'b1100; b = 4'b1010; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("xor_y", 32'(y), 32'(4'b0110));
`ifdef GATE_PARITY_EN
        chk("xor_par", 32'(y_par), 32'd0);
        op = 3'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("and_par", 32'(y_par), 32'd1);
`endif
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
